// File: rtl/spike_rate_decoder_if.sv
// Control and readback bundle for spike_rate_decoder.
// Defining SPIKE_ISI_EN adds the inter-spike-interval readback signals.
interface spike_rate_decoder_if;
  localparam int unsigned RATE_W = 8;

  logic              ena;
  logic              clear;
  logic              spike_in;
  logic [RATE_W-1:0] rate_out;
  logic              rate_valid;
  logic              rate_sat;
`ifdef SPIKE_ISI_EN
  logic [RATE_W-1:0] isi_out;
  logic              isi_valid;
`endif

`ifdef SPIKE_ISI_EN
  modport master (output ena, clear, spike_in,
                  input  rate_out, rate_valid, rate_sat, isi_out, isi_valid);
  modport slave  (input  ena, clear, spike_in,
                  output rate_out, rate_valid, rate_sat, isi_out, isi_valid);
`else
  modport master (output ena, clear, spike_in,
                  input  rate_out, rate_valid, rate_sat);
  modport slave  (input  ena, clear, spike_in,
                  output rate_out, rate_valid, rate_sat);
`endif
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts rising edges of a spike line over back-to-back windows of WINDOW cycles.
// Optional SPIKE_ISI_EN macro adds an inter-spike-interval measurement.
module spike_rate_decoder #(
  parameter int unsigned WINDOW = 1_000_000,
  parameter int unsigned WIN_W  = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  spike_rate_decoder_if.slave bus
);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {IDLE, COUNT} state_t;

  state_t           state_q, state_d;
  logic             spike_d;
  logic [WIN_W-1:0] win_cnt, win_cnt_d;
  logic [CNT_W-1:0] spk_cnt, spk_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] rate_out_q, rate_out_d;
  logic             rate_valid_q, rate_valid_d;
  logic             rate_sat_q, rate_sat_d;

  logic             spk_edge_c;
  logic             win_end_c;
  logic [CNT_W-1:0] spk_next_c;

`ifdef SPIKE_ISI_EN
  logic [CNT_W-1:0] isi_cnt, isi_cnt_d;
  logic             isi_armed, isi_armed_d;
  logic [CNT_W-1:0] isi_out_q, isi_out_d;
  logic             isi_valid_q, isi_valid_d;
`endif

  assign spk_edge_c = bus.spike_in & ~spike_d;
  assign win_end_c  = (win_cnt == WIN_W'(WINDOW - 1));
  assign spk_next_c = (spk_cnt == CNT_MAX) ? spk_cnt : spk_cnt + CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      spike_d      <= 1'b0;
      win_cnt      <= '0;
      spk_cnt      <= '0;
      sat_q        <= 1'b0;
      rate_out_q   <= '0;
      rate_valid_q <= 1'b0;
      rate_sat_q   <= 1'b0;
`ifdef SPIKE_ISI_EN
      isi_cnt      <= '0;
      isi_armed    <= 1'b0;
      isi_out_q    <= '0;
      isi_valid_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      spike_d      <= bus.spike_in;
      win_cnt      <= win_cnt_d;
      spk_cnt      <= spk_cnt_d;
      sat_q        <= sat_d;
      rate_out_q   <= rate_out_d;
      rate_valid_q <= rate_valid_d;
      rate_sat_q   <= rate_sat_d;
`ifdef SPIKE_ISI_EN
      isi_cnt      <= isi_cnt_d;
      isi_armed    <= isi_armed_d;
      isi_out_q    <= isi_out_d;
      isi_valid_q  <= isi_valid_d;
`endif
    end
  end

  // Next state: ena low > clear > window end > edge count.
  // The first ena cycle in IDLE is window cycle 0 (win_cnt is 0 there).
  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt;
    spk_cnt_d    = spk_cnt;
    sat_d        = sat_q;
    rate_out_d   = rate_out_q;
    rate_valid_d = 1'b0;
    rate_sat_d   = rate_sat_q;
`ifdef SPIKE_ISI_EN
    isi_cnt_d    = isi_cnt;
    isi_armed_d  = isi_armed;
    isi_out_d    = isi_out_q;
    isi_valid_d  = 1'b0;
`endif

    if (!bus.ena || (state_q == COUNT && bus.clear)) begin
      state_d   = bus.ena ? COUNT : IDLE;
      win_cnt_d = '0;
      spk_cnt_d = '0;
      sat_d     = 1'b0;
`ifdef SPIKE_ISI_EN
      isi_cnt_d   = '0;
      isi_armed_d = 1'b0;
`endif
    end else begin
      state_d = COUNT;
      if (state_q == COUNT && win_end_c) begin
        rate_out_d   = spk_edge_c ? spk_next_c : spk_cnt;
        rate_sat_d   = sat_q | (spk_edge_c & (spk_cnt == CNT_MAX));
        rate_valid_d = 1'b1;
        win_cnt_d    = '0;
        spk_cnt_d    = '0;
        sat_d        = 1'b0;
      end else begin
        win_cnt_d = win_cnt + WIN_W'(1);
        if (spk_edge_c) begin
          spk_cnt_d = spk_next_c;
          sat_d     = sat_q | (spk_cnt == CNT_MAX);
        end
      end
`ifdef SPIKE_ISI_EN
      // Interval runs across window boundaries; only clear/IDLE re-arm it
      if (spk_edge_c) begin
        if (isi_armed) begin
          isi_out_d   = isi_cnt;
          isi_valid_d = 1'b1;
        end
        isi_cnt_d   = CNT_W'(1);
        isi_armed_d = 1'b1;
      end else if (isi_armed && isi_cnt != CNT_MAX) begin
        isi_cnt_d = isi_cnt + CNT_W'(1);
      end
`endif
    end
  end

  assign bus.rate_out   = rate_out_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.rate_sat   = rate_sat_q;
`ifdef SPIKE_ISI_EN
  assign bus.isi_out    = isi_out_q;
  assign bus.isi_valid  = isi_valid_q;
`endif

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receiving end of the neuron spike line: turns a 1-bit spike train back into an 8-bit rate value.
- Counts rising edges of spike_in over a fixed window of WINDOW clock cycles.
- At each window end, latches the count onto rate_out and pulses rate_valid for one cycle.
- Sits after lif_neuron in the tt_um top, driving uo_out/uio_out for readback of the firing rate.

Parameters:
- WINDOW, 24'd1_000_000, window length in clock cycles; legal range 2 to 2^24-1.
- WIN_W, 24, width of the window counter; must hold WINDOW-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  counting enable; low idles the block.
- clear  input  1  synchronous restart of the current window.
- spike_in  input  1  spike line from the neuron; may stay high for several cycles.
- rate_out  output  8  spike count of the last completed window.
- rate_valid  output  1  one-cycle pulse when rate_out updates.
- rate_sat  output  1  set if the last completed window saturated at 255.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following are 0: rate_out, rate_valid, rate_sat, spike_d, win_cnt, spk_cnt, sat flag, isi registers. State = IDLE.
- Edge detect: spike_d is spike_in registered. edge = spike_in & ~spike_d. spike_d updates every cycle, including in IDLE. A held-high spike counts once.
- States:
  - IDLE: entered on reset or ena low. win_cnt and spk_cnt held at 0. rate_out and rate_sat hold their values. rate_valid = 0.
  - Leave IDLE for COUNT on the first clock edge with ena=1. That cycle is window cycle 0, and an edge in that cycle counts.
- COUNT, per cycle:
  - win_cnt increments.
  - On an edge, spk_cnt = min(spk_cnt+1, 255). The sat flag sets if an edge arrives while spk_cnt == 255.
- Window end (win_cnt == WINDOW-1):
  - The edge in that cycle is included.
  - On the following clock edge: rate_out = final count, rate_sat = sat flag, rate_valid = 1 for exactly one cycle.
  - win_cnt, spk_cnt and the sat flag reset to 0, and the next window starts in that same cycle. No dead cycle: windows are back-to-back, with period exactly WINDOW cycles.
- ena falls mid-window: next edge goes to IDLE. The partial window is discarded; no rate_valid, rate_out unchanged.
- clear=1 in COUNT: win_cnt, spk_cnt and the sat flag go to 0, and the window restarts. No rate_valid, rate_out unchanged, edge in that cycle not counted. clear in IDLE has no effect.
- clear at the window-end cycle: clear wins. No valid pulse, no rate_out update.
- Priority: rst_n > ena low > clear > window end > edge count.
- Simultaneous window end and edge at spk_cnt=255: rate_out=255, rate_sat=1.

Optional Feature:
- Macro: SPIKE_ISI_EN.
- When defined, the block adds:
  - output isi_out [7:0]: cycles between the two most recent edges, saturating at 255.
  - output isi_valid [0:0]: one-cycle pulse on each edge after the first since reset or leaving IDLE.
- The ISI counter runs in COUNT only and resets to 1 on each edge. clear and IDLE reset it and re-arm the "first edge" condition.
- When undefined, neither port nor any ISI logic exists.

Test Plan:
- WINDOW=8: reset, then ena=1 with spike_in=0 → rate_valid pulses exactly 8 cycles apart, rate_out=0, rate_sat=0.
- WINDOW=8: 1-cycle spikes in window cycles 0, 3 and 7 → rate_out=3 with valid one cycle after cycle 7. Next window with no spikes → rate_out=0.
- WINDOW=8: spike_in held high for 5 cycles → count 1. Spike on 1/0/1/0 alternation over 8 cycles → count 4.
- WINDOW=300: spike toggling every cycle (150 edges) → rate_out=150. Then WINDOW=600 with continuous toggling (300 edges) → rate_out=255, rate_sat=1.
- WINDOW=8, with 2 spikes already counted:
  - ena dropped at cycle 4 → no valid, rate_out unchanged.
  - clear pulsed at cycle 5 → window restarts and the next valid appears 8 cycles after clear.
  - rst_n asserted asynchronously mid-window → all outputs 0 immediately.
- SPIKE_ISI_EN defined, WINDOW=64: edges at cycles 2, 7 and 30 → isi_valid at the 2nd and 3rd edges with isi_out=5 then 23. Edges 400 cycles apart → isi_out=255.
